problemalcd_led_blink_ctrl: RTL and testbench

Avalon-MM master-side sequencer that drives the single-bit LED PIO slave (register at address 0, write-only effect on bit 0) from a simple command interface. It turns OFF, ON, and timed BLINK commands into correctly spaced single-cycle PIO write strobes. It also keeps a shadow of the LED state and signals completion. It sits between the Nios/control logic and the LED PIO in the problemaLCD system, so software no longer bit-bangs the LED.

---
 rtl/problemaLCD_led_ctrl_pkg.sv | 20 ++
 rtl/problemaLCD_led_timer.sv | 37 +++
 rtl/problemalcd_led_blink_ctrl.sv | 145 ++++++++++++++
 tb/tb_problemalcd_led_blink_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/problemaLCD_led_ctrl_pkg.sv
// Shared encodings for the LED PIO blink sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package problemaLCD_led_ctrl_pkg;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;

    localparam logic [1:0] PIO_DATA_ADDR   = 2'd0;
    localparam int         MIN_HALF_PERIOD = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/problemaLCD_led_timer.sv
// Loadable down-counter spacing blink strobes.
// Latency: load visible next cycle; zero flag is combinational from the count.
// Backpressure: none; load has priority over enable, count holds at zero.
module problemaLCD_led_timer #(
    parameter int DIV_WIDTH = 26
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] load_val,
    output logic                 zero
);

    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - DIV_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/problemalcd_led_blink_ctrl.sv
// Turns OFF/ON/BLINK commands into single-cycle Avalon-MM writes to the LED PIO.
// Latency: first strobe one cycle after handshake; blink strobes H cycles apart.
// Backpressure: cmd_ready only in IDLE; PIO has no waitrequest.
module problemalcd_led_blink_ctrl
    import problemaLCD_led_ctrl_pkg::*;
#(
    parameter int DIV_WIDTH = 26,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_mode,
    input  logic [DIV_WIDTH-1:0] cmd_half_period,
    input  logic [CNT_WIDTH-1:0] cmd_count,
    input  logic                 abort,
    output logic [1:0]           avm_address,
    output logic                 avm_chipselect,
    output logic                 avm_write_n,
    output logic [31:0]          avm_writedata,
    output logic                 busy,
    output logic                 done,
    output logic                 led_state
);

    state_e               state_q,  state_d;
    logic [1:0]           mode_q,   mode_d;
    logic [DIV_WIDTH-1:0] half_q,   half_d;
    logic [CNT_WIDTH-1:0] count_q,  count_d;
    logic [CNT_WIDTH:0]   toggle_q, toggle_d;
    logic                 target_q, target_d;
    logic                 abort_q,  abort_d;
    logic                 led_q,    led_d;
    logic                 tmr_load, tmr_en, tmr_zero;
    logic                 strobe;

    problemaLCD_led_timer #(.DIV_WIDTH(DIV_WIDTH)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (half_q - DIV_WIDTH'(MIN_HALF_PERIOD)),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_OFF;
            half_q   <= DIV_WIDTH'(MIN_HALF_PERIOD);
            count_q  <= '0;
            toggle_q <= '0;
            target_q <= 1'b0;
            abort_q  <= 1'b0;
            led_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            half_q   <= half_d;
            count_q  <= count_d;
            toggle_q <= toggle_d;
            target_q <= target_d;
            abort_q  <= abort_d;
            led_q    <= led_d;
        end
    end

    // toggle_q counts strobes issued including the one in the current WRITE.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        half_d   = half_q;
        count_d  = count_q;
        toggle_d = toggle_q;
        target_d = target_q;
        abort_d  = abort_q;
        led_d    = led_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    mode_d   = (cmd_mode == MODE_BLINK) ? MODE_BLINK :
                               (cmd_mode == MODE_ON)    ? MODE_ON : MODE_OFF;
                    half_d   = (cmd_half_period < DIV_WIDTH'(MIN_HALF_PERIOD)) ?
                               DIV_WIDTH'(MIN_HALF_PERIOD) : cmd_half_period;
                    count_d  = cmd_count;
                    target_d = (cmd_mode == MODE_ON) || (cmd_mode == MODE_BLINK);
                    toggle_d = (CNT_WIDTH+1)'(1);
                    abort_d  = 1'b0;
                    state_d  = ST_WRITE;
                end
            end
            ST_WRITE: begin
                led_d = target_q;
                // Finite completion wins over abort so the last 0-write is never repeated.
                if ((mode_q != MODE_BLINK) || abort_q) begin
                    state_d = ST_DONE;
                end else if ((count_q != '0) && (toggle_q == {count_q, 1'b0})) begin
                    state_d = ST_DONE;
                end else if (abort) begin
                    abort_d  = 1'b1;
                    target_d = 1'b0;
                end else begin
                    tmr_load = 1'b1;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    abort_d  = 1'b1;
                    target_d = 1'b0;
                    state_d  = ST_WRITE;
                end else if (tmr_zero) begin
                    target_d = ~target_q;
                    toggle_d = (toggle_q == '1) ? toggle_q : toggle_q + (CNT_WIDTH+1)'(1);
                    state_d  = ST_WRITE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Gating with reset kills a strobe in the very cycle reset is sampled.
    always_comb begin
        strobe         = (state_q == ST_WRITE) && !reset;
        cmd_ready      = (state_q == ST_IDLE) && !reset;
        busy           = (state_q != ST_IDLE) && !reset;
        done           = (state_q == ST_DONE) && !reset;
        avm_address    = PIO_DATA_ADDR;
        avm_chipselect = strobe;
        avm_write_n    = !strobe;
        avm_writedata  = strobe ? {31'b0, target_q} : 32'b0;
        led_state      = led_q;
    end

endmodule

// File: tb/tb_problemalcd_led_blink_ctrl.sv
// Directed bench for the LED blink sequencer: strobe timing, data and completion.
module tb_problemalcd_led_blink_ctrl;

    localparam int DW = 26;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_mode;
    logic [DW-1:0] cmd_half_period;
    logic [CW-1:0] cmd_count;
    logic          abort;
    logic [1:0]    avm_address;
    logic          avm_chipselect;
    logic          avm_write_n;
    logic [31:0]   avm_writedata;
    logic          busy;
    logic          done;
    logic          led_state;

    int cyc = 0;
    int chk_cnt = 0;
    int pass_cnt = 0;
    int stb_cyc[$];
    int stb_dat[$];
    int done_cyc[$];

    problemalcd_led_blink_ctrl #(.DIV_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_mode        (cmd_mode),
        .cmd_half_period (cmd_half_period),
        .cmd_count       (cmd_count),
        .abort           (abort),
        .avm_address     (avm_address),
        .avm_chipselect  (avm_chipselect),
        .avm_write_n     (avm_write_n),
        .avm_writedata   (avm_writedata),
        .busy            (busy),
        .done            (done),
        .led_state       (led_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (avm_chipselect && !avm_write_n) begin
            stb_cyc.push_back(cyc);
            stb_dat.push_back(int'(avm_writedata));
        end
        if (done) done_cyc.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        stb_cyc.delete();
        stb_dat.delete();
        done_cyc.delete();
    endtask

    // Handshake in the current cycle; returns with the bench in cycle T+1.
    task automatic send(input logic [1:0] m, input int h, input int n, output int t);
        for (int i = 0; i < 100 && !cmd_ready; i++) tick();
        if (!cmd_ready) chk("ready_timeout", 32'(cmd_ready), 32'd1);
        cmd_valid       = 1'b1;
        cmd_mode        = m;
        cmd_half_period = DW'(h);
        cmd_count       = CW'(n);
        t = cyc;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int i;
        for (i = 0; i < limit && !done; i++) tick();
        if (!done) chk("done_timeout", 32'(done), 32'd1);
        tick();
    endtask

    task automatic blink_check(input string tag, input int h, input int n);
        int t;
        clear_log();
        send(2'd2, h, n, t);
        wait_done(2000);
        repeat (3) tick();
        chk({tag, "_nstb"}, 32'(stb_cyc.size()), 32'(2 * n));
        if (stb_cyc.size() == 2 * n) begin
            int hc;
            hc = (h < 2) ? 2 : h;
            chk({tag, "_first"}, 32'(stb_cyc[0]), 32'(t + 1));
            for (int i = 1; i < 2 * n; i++) begin
                chk({tag, "_space"}, 32'(stb_cyc[i] - stb_cyc[i-1]), 32'(hc));
                chk({tag, "_dat"}, 32'(stb_dat[i]), 32'((i % 2 == 0) ? 1 : 0));
            end
            chk({tag, "_last"}, 32'(stb_cyc[2*n-1]), 32'(t + 1 + (2 * n - 1) * hc));
            if (done_cyc.size() == 1)
                chk({tag, "_done"}, 32'(done_cyc[0]), 32'(t + 2 + (2 * n - 1) * hc));
            else
                chk({tag, "_ndone"}, 32'(done_cyc.size()), 32'd1);
        end
        chk({tag, "_led"}, 32'(led_state), 32'd0);
    endtask

    initial begin
        int t, a, nseen;
        reset = 1'b1; cmd_valid = 1'b0; cmd_mode = '0;
        cmd_half_period = '0; cmd_count = '0; abort = 1'b0;
        tick(); tick();
        chk("rst_ready_low", 32'(cmd_ready), 32'd0);
        chk("rst_cs", 32'(avm_chipselect), 32'd0);
        reset = 1'b0;
        tick();
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_led", 32'(led_state), 32'd0);
        chk("rst_wn", 32'(avm_write_n), 32'd1);
        chk("rst_wd", avm_writedata, 32'd0);
        chk("rst_addr", 32'(avm_address), 32'd0);

        // OFF then ON: strobe at T+1, done at T+2, ready back at T+3.
        for (int k = 0; k < 2; k++) begin
            send(2'(k), 7, 3, t);
            chk("cmd_cs", 32'(avm_chipselect), 32'd1);
            chk("cmd_wn", 32'(avm_write_n), 32'd0);
            chk("cmd_wd", avm_writedata, 32'(k));
            chk("cmd_ready_t1", 32'(cmd_ready), 32'd0);
            chk("cmd_busy_t1", 32'(busy), 32'd1);
            tick();
            chk("cmd_done_t2", 32'(done), 32'd1);
            chk("cmd_cs_t2", 32'(avm_chipselect), 32'd0);
            chk("cmd_ready_t2", 32'(cmd_ready), 32'd0);
            tick();
            chk("cmd_ready_t3", 32'(cmd_ready), 32'd1);
            chk("cmd_done_t3", 32'(done), 32'd0);
            chk("cmd_led", 32'(led_state), 32'(k));
        end

        // Reserved mode behaves as OFF.
        send(2'd3, 5, 1, t);
        chk("rsv_wd", avm_writedata, 32'd0);
        wait_done(10);
        chk("rsv_led", 32'(led_state), 32'd0);

        blink_check("b_h5n3", 5, 3);
        blink_check("b_h0n2", 0, 2);
        blink_check("b_h1n1", 1, 1);
        blink_check("b_h2n2", 2, 2);

        // Endless blink, abort pulse in WAIT after 10 strobes.
        clear_log();
        send(2'd2, 4, 0, t);
        nseen = 1;
        for (int i = 0; i < 200 && nseen < 10; i++) begin
            tick();
            if (avm_chipselect) nseen++;
        end
        chk("end_10", 32'(nseen), 32'd10);
        tick();
        chk("end_in_wait", 32'(avm_chipselect), 32'd0);
        abort = 1'b1; a = cyc;
        tick();
        abort = 1'b0;
        chk("abw_cs", 32'(avm_chipselect), 32'd1);
        chk("abw_wd", avm_writedata, 32'd0);
        tick();
        chk("abw_done", 32'(done), 32'd1);
        repeat (8) tick();
        chk("abw_nstb", 32'(stb_cyc.size()), 32'd11);
        if (stb_cyc.size() == 11) chk("abw_cyc", 32'(stb_cyc[10]), 32'(a + 1));
        chk("abw_led", 32'(led_state), 32'd0);

        // Abort held during a WRITE: current write completes, one extra 0-write.
        clear_log();
        send(2'd2, 4, 0, t);
        nseen = 1;
        for (int i = 0; i < 100 && nseen < 3; i++) begin
            tick();
            if (avm_chipselect) nseen++;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abr_cs", 32'(avm_chipselect), 32'd1);
        chk("abr_wd", avm_writedata, 32'd0);
        tick();
        chk("abr_done", 32'(done), 32'd1);
        repeat (8) tick();
        chk("abr_nstb", 32'(stb_cyc.size()), 32'd4);
        if (stb_cyc.size() == 4) begin
            chk("abr_d2", 32'(stb_dat[2]), 32'd1);
            chk("abr_gap", 32'(stb_cyc[3] - stb_cyc[2]), 32'd1);
        end

        // cmd_valid while busy is ignored.
        clear_log();
        send(2'd2, 3, 1, t);
        tick();
        cmd_valid = 1'b1; cmd_mode = 2'd1;
        tick(); tick();
        cmd_valid = 1'b0;
        wait_done(50);
        repeat (6) tick();
        chk("busy_nstb", 32'(stb_cyc.size()), 32'd2);
        chk("busy_ndone", 32'(done_cyc.size()), 32'd1);
        chk("busy_led", 32'(led_state), 32'd0);

        // Reset in the middle of WAIT.
        clear_log();
        send(2'd2, 6, 0, t);
        tick(); tick();
        reset = 1'b1;
        #0;
        chk("mrst_cs", 32'(avm_chipselect), 32'd0);
        chk("mrst_ready", 32'(cmd_ready), 32'd0);
        tick();
        chk("mrst_led", 32'(led_state), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_wn", 32'(avm_write_n), 32'd1);
        reset = 1'b0;
        tick();
        chk("mrst_ready1", 32'(cmd_ready), 32'd1);
        repeat (10) tick();
        chk("mrst_nstb", 32'(stb_cyc.size()), 32'd1);
        send(2'd1, 2, 0, t);
        chk("mrst_on_wd", avm_writedata, 32'd1);
        tick();
        chk("mrst_on_done", 32'(done), 32'd1);
        chk("mrst_on_led", 32'(led_state), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
